// File: rtl/pc_sequencer.sv
// Next-PC controller: boot hold, redirect priority, stall-time redirect buffering.
// Optional exception entry and EPC capture are built when SEQ_EXCEPTION_EN is defined.
module pc_sequencer #(
    parameter int unsigned       N_BITS      = 32,
    parameter logic [N_BITS-1:0] RESET_PC    = 32'h0040_0000,
    parameter int unsigned       BOOT_CYCLES = 2,
    parameter logic [N_BITS-1:0] EXC_VECTOR  = 32'h8000_0180
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_BITS-1:0] pc_value_i,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic [N_BITS-1:0] branch_target_i,
    input  logic              jump_i,
    input  logic [N_BITS-1:0] jump_target_i,
    input  logic              jr_i,
    input  logic [N_BITS-1:0] jr_target_i,
`ifdef SEQ_EXCEPTION_EN
    input  logic              exc_i,
    input  logic [N_BITS-1:0] exc_pc_i,
    output logic [N_BITS-1:0] epc_o,
`endif
    output logic [N_BITS-1:0] new_pc_o,
    output logic              fetch_valid_o,
    output logic              flush_o,
    output logic              redirect_pending_o
);

    localparam logic [1:0] StBoot = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StPend = 2'd2;

    logic [1:0]        r_state, w_state_next;
    logic [3:0]        r_boot_cnt, w_boot_cnt_next;
    logic [N_BITS-1:0] r_pend_target, w_pend_target_next;
    logic [N_BITS-1:0] w_pc_plus4;
    logic [N_BITS-1:0] w_raw_target;
    logic [N_BITS-1:0] w_target;
    logic              w_redirect;
`ifdef SEQ_EXCEPTION_EN
    logic [N_BITS-1:0] r_epc, w_epc_next;
    logic              w_misaligned;
`endif

    assign w_pc_plus4 = pc_value_i + N_BITS'(4);
    assign w_redirect = branch_taken_i | jr_i | jump_i;

    // EX-stage branch is older than the ID-stage jumps, so it wins.
    always_comb begin
        if (branch_taken_i) begin
            w_raw_target = branch_target_i;
        end else if (jr_i) begin
            w_raw_target = jr_target_i;
        end else begin
            w_raw_target = jump_target_i;
        end
    end

    assign w_target = w_raw_target & ~N_BITS'(3);

`ifdef SEQ_EXCEPTION_EN
    assign w_misaligned = w_redirect && (w_raw_target[1:0] != 2'b00);
    assign epc_o        = r_epc;
`endif

    always_comb begin
        new_pc_o           = pc_value_i;
        fetch_valid_o      = 1'b0;
        flush_o            = 1'b0;
        w_state_next       = r_state;
        w_boot_cnt_next    = r_boot_cnt;
        w_pend_target_next = r_pend_target;
`ifdef SEQ_EXCEPTION_EN
        w_epc_next         = r_epc;
`endif
        if (!reset) begin
            new_pc_o = RESET_PC;
        end else begin
            case (r_state)
                StBoot: begin
                    new_pc_o = RESET_PC;
                    if (r_boot_cnt <= 4'd1) begin
                        w_boot_cnt_next = 4'd0;
                        w_state_next    = StRun;
                    end else begin
                        w_boot_cnt_next = r_boot_cnt - 4'd1;
                    end
                end
                StRun: begin
`ifdef SEQ_EXCEPTION_EN
                    if (exc_i) begin
                        new_pc_o   = EXC_VECTOR;
                        flush_o    = 1'b1;
                        w_epc_next = exc_pc_i;
                    end else if (w_misaligned) begin
                        new_pc_o   = EXC_VECTOR;
                        flush_o    = 1'b1;
                        w_epc_next = w_raw_target;
                    end else
`endif
                    if (w_redirect) begin
                        if (stall_i) begin
                            w_pend_target_next = w_target;
                            w_state_next       = StPend;
                        end else begin
                            new_pc_o = w_target;
                            flush_o  = 1'b1;
                        end
                    end else if (!stall_i) begin
                        new_pc_o      = w_pc_plus4;
                        fetch_valid_o = 1'b1;
                    end
                end
                StPend: begin
                    // Redirects seen here are wrong-path and dropped.
`ifdef SEQ_EXCEPTION_EN
                    if (exc_i) begin
                        new_pc_o           = EXC_VECTOR;
                        flush_o            = 1'b1;
                        w_epc_next         = exc_pc_i;
                        w_pend_target_next = '0;
                        w_state_next       = StRun;
                    end else
`endif
                    if (!stall_i) begin
                        new_pc_o     = r_pend_target;
                        flush_o      = 1'b1;
                        w_state_next = StRun;
                    end
                end
                default: begin
                    new_pc_o     = RESET_PC;
                    w_state_next = StBoot;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= StBoot;
            r_boot_cnt    <= 4'(BOOT_CYCLES);
            r_pend_target <= '0;
`ifdef SEQ_EXCEPTION_EN
            r_epc         <= '0;
`endif
        end else begin
            r_state       <= w_state_next;
            r_boot_cnt    <= w_boot_cnt_next;
            r_pend_target <= w_pend_target_next;
`ifdef SEQ_EXCEPTION_EN
            r_epc         <= w_epc_next;
`endif
        end
    end

    assign redirect_pending_o = (r_state == StPend);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, corner sequences, random vs reference model.
// Exception checks are compiled only when SEQ_EXCEPTION_EN is defined.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC    = 32'h0040_0000;
    localparam int          BOOT_CYCLES = 2;
    localparam logic [31:0] EXC_VECTOR  = 32'h8000_0180;
    localparam int          BOOT_LEN    = (BOOT_CYCLES == 0) ? 1 : BOOT_CYCLES;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_value_i;
    logic        stall_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        jump_i;
    logic [31:0] jump_target_i;
    logic        jr_i;
    logic [31:0] jr_target_i;
    logic [31:0] new_pc_o;
    logic        fetch_valid_o;
    logic        flush_o;
    logic        redirect_pending_o;
`ifdef SEQ_EXCEPTION_EN
    logic        exc_i;
    logic [31:0] exc_pc_i;
    logic [31:0] epc_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    pc_sequencer #(
        .N_BITS     (32),
        .RESET_PC   (RESET_PC),
        .BOOT_CYCLES(BOOT_CYCLES),
        .EXC_VECTOR (EXC_VECTOR)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .pc_value_i        (pc_value_i),
        .stall_i           (stall_i),
        .branch_taken_i    (branch_taken_i),
        .branch_target_i   (branch_target_i),
        .jump_i            (jump_i),
        .jump_target_i     (jump_target_i),
        .jr_i              (jr_i),
        .jr_target_i       (jr_target_i),
`ifdef SEQ_EXCEPTION_EN
        .exc_i             (exc_i),
        .exc_pc_i          (exc_pc_i),
        .epc_o             (epc_o),
`endif
        .new_pc_o          (new_pc_o),
        .fetch_valid_o     (fetch_valid_o),
        .flush_o           (flush_o),
        .redirect_pending_o(redirect_pending_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] brt;
        logic        j;
        logic [31:0] jt;
        logic        jr;
        logic [31:0] jrt;
        logic [31:0] pc;
        logic [31:0] e_pc;
        logic        e_fv;
        logic        e_fl;
        logic        e_pend;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic stall,
                                input logic br, input logic [31:0] brt,
                                input logic j, input logic [31:0] jt,
                                input logic jr, input logic [31:0] jrt,
                                input logic [31:0] pc, input logic [31:0] e_pc,
                                input logic e_fv, input logic e_fl, input logic e_pend);
        vec_t v;
        v.rst = rst; v.stall = stall; v.br = br; v.brt = brt; v.j = j; v.jt = jt;
        v.jr = jr; v.jrt = jrt; v.pc = pc; v.e_pc = e_pc; v.e_fv = e_fv; v.e_fl = e_fl;
        v.e_pend = e_pend;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic stall, input logic br,
                         input logic [31:0] brt, input logic j, input logic [31:0] jt,
                         input logic jr, input logic [31:0] jrt, input logic [31:0] pc);
        reset = rst; stall_i = stall; branch_taken_i = br; branch_target_i = brt;
        jump_i = j; jump_target_i = jt; jr_i = jr; jr_target_i = jrt; pc_value_i = pc;
    endtask

    task automatic check_outs(input string tag, input logic [31:0] e_pc, input logic e_fv,
                              input logic e_fl, input logic e_pend);
        check({tag, " new_pc"}, new_pc_o, e_pc);
        check({tag, " fetch_valid"}, 32'(fetch_valid_o), 32'(e_fv));
        check({tag, " flush"}, 32'(flush_o), 32'(e_fl));
        check({tag, " pending"}, 32'(redirect_pending_o), 32'(e_pend));
    endtask

    // Reference model: cycles since reset release plus a pending flag.
    int          m_rel;
    logic        m_pending;
    logic [31:0] m_tgt;
    logic [31:0] m_epc;
    logic [31:0] e_pc;
    logic        e_fv, e_fl, e_pend;

    function automatic logic [31:0] winner();
        if (branch_taken_i) return branch_target_i;
        if (jr_i) return jr_target_i;
        return jump_target_i;
    endfunction

    task automatic model_eval();
        logic        redir;
        logic [31:0] raw;
        redir  = branch_taken_i | jump_i | jr_i;
        raw    = winner();
        e_pend = m_pending;
        e_fv   = 1'b0;
        e_fl   = 1'b0;
        e_pc   = pc_value_i;
        if (!reset) e_pc = RESET_PC;
        else if (m_rel < BOOT_LEN) e_pc = RESET_PC;
`ifdef SEQ_EXCEPTION_EN
        else if (exc_i) begin e_pc = EXC_VECTOR; e_fl = 1'b1; end
        else if (!m_pending && redir && (raw % 4 != 0)) begin e_pc = EXC_VECTOR; e_fl = 1'b1; end
`endif
        else if (m_pending) begin
            if (!stall_i) begin e_pc = m_tgt; e_fl = 1'b1; end
        end else if (redir) begin
            if (!stall_i) begin e_pc = raw - (raw % 4); e_fl = 1'b1; end
        end else if (!stall_i) begin
            e_pc = pc_value_i + 32'd4;
            e_fv = 1'b1;
        end
    endtask

    task automatic model_step();
        logic        redir;
        logic [31:0] raw;
        redir = branch_taken_i | jump_i | jr_i;
        raw   = winner();
        if (!reset) begin m_rel = 0; m_pending = 1'b0; m_epc = '0; end
        else if (m_rel < BOOT_LEN) m_rel++;
`ifdef SEQ_EXCEPTION_EN
        else if (exc_i) begin m_epc = exc_pc_i; m_pending = 1'b0; end
        else if (!m_pending && redir && (raw % 4 != 0)) m_epc = raw;
`endif
        else if (m_pending) begin
            if (!stall_i) m_pending = 1'b0;
        end else if (redir && stall_i) begin
            m_pending = 1'b1;
            m_tgt     = raw - (raw % 4);
        end
    endtask

    function automatic logic [31:0] rnd_target();
        logic [31:0] t;
        t = $urandom();
        if ($urandom_range(3) != 0) t[1:0] = 2'b00;
        return t;
    endfunction

    initial begin
        logic [31:0] pc_cur;
`ifdef SEQ_EXCEPTION_EN
        exc_i = 1'b0; exc_pc_i = '0;
`endif
        drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 0);

        //        rst  stl  br  brt           j   jt            jr  jrt           pc            e_pc          fv fl pd
        tbl.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,            32'h0,        RESET_PC,     0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,            32'h0,        RESET_PC,     0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,            32'h0,        RESET_PC,     0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 32'h0040_0100, 0, 0,            0, 0,            RESET_PC,     RESET_PC,     0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,            RESET_PC,     RESET_PC,     0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,            RESET_PC,     32'h0040_0004, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,            32'h0040_0004, 32'h0040_0008, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 32'h0040_0100, 1, 32'h0040_0200, 0, 0,            32'h0040_0010, 32'h0040_0100, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,            32'h0040_0100, 32'h0040_0104, 1, 0, 0));
        tbl.push_back(mk(1, 1, 1, 32'h0040_0080, 0, 0,            0, 0,            32'h0040_0104, 32'h0040_0104, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0,            1, 32'h0040_0300, 0, 0,            32'h0040_0104, 32'h0040_0104, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0,            0, 0,            0, 0,            32'h0040_0104, 32'h0040_0104, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0,            0, 0,            0, 0,            32'h0040_0104, 32'h0040_0104, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,            32'h0040_0104, 32'h0040_0080, 0, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,            32'h0040_0080, 32'h0040_0084, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0,            0, 0,            1, 32'h0040_0500, 32'h0040_0084, 32'h0040_0084, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0,            32'h0040_0084, RESET_PC,     0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,            RESET_PC,     RESET_PC,     0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,            RESET_PC,     RESET_PC,     0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,            RESET_PC,     32'h0040_0004, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,            32'hFFFF_FFFC, 32'h0000_0000, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,            1, 32'h0040_0600, 1, 32'h0040_0500, 32'h0040_0200, 32'h0040_0500, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0,            0, 0,            0, 0,            32'h0040_0200, 32'h0040_0200, 0, 0, 0));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].stall, tbl[i].br, tbl[i].brt, tbl[i].j, tbl[i].jt,
                  tbl[i].jr, tbl[i].jrt, tbl[i].pc);
            #1;
            check_outs($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_fv, tbl[i].e_fl,
                       tbl[i].e_pend);
        end

`ifdef SEQ_EXCEPTION_EN
        // Exception while stalled in RUN.
        @(negedge clk);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 32'h0040_0200);
        exc_i = 1'b1; exc_pc_i = 32'h0040_0040;
        #1 check_outs("exc_stall", EXC_VECTOR, 0, 1, 0);
        @(negedge clk);
        exc_i = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0, 0, EXC_VECTOR);
        #1 check_outs("exc_after", EXC_VECTOR + 32'd4, 1, 0, 0);
        check("exc epc", epc_o, 32'h0040_0040);
        // Misaligned jr target raises an internal exception.
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 1, 32'h0040_0042, 32'h0040_0300);
        #1 check_outs("misalign", EXC_VECTOR, 0, 1, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, EXC_VECTOR);
        #1 check("misalign epc", epc_o, 32'h0040_0042);
        // Exception during PEND drops the buffered redirect.
        @(negedge clk);
        drive(1, 1, 1, 32'h0040_0700, 0, 0, 0, 0, 32'h0040_0400);
        @(negedge clk);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 32'h0040_0400);
        exc_i = 1'b1; exc_pc_i = 32'h0040_0800;
        #1 check_outs("pend_exc", EXC_VECTOR, 0, 1, 1);
        @(negedge clk);
        exc_i = 1'b0;
        drive(1, 1, 0, 0, 0, 0, 0, 0, EXC_VECTOR);
        #1 check_outs("pend_exc_clr", EXC_VECTOR, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, EXC_VECTOR);
        #1 check_outs("pend_exc_run", EXC_VECTOR + 32'd4, 1, 0, 0);
        check("pend_exc epc", epc_o, 32'h0040_0800);
`else
        // Misaligned target is silently masked.
        @(negedge clk);
        drive(1, 0, 0, 0, 1, 32'h0040_0203, 0, 0, 32'h0040_0100);
        #1 check_outs("mask", 32'h0040_0200, 0, 1, 0);
        @(negedge clk);
        drive(1, 1, 1, 32'h0040_0301, 0, 0, 0, 0, 32'h0040_0200);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0200);
        #1 check_outs("mask_pend", 32'h0040_0300, 0, 1, 1);
`endif

        // Random phase against the reference model.
        pc_cur = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            drive((c == 0) ? 1'b0 : ($urandom_range(39) != 0),
                  ($urandom_range(2) == 0),
                  ($urandom_range(5) == 0), rnd_target(),
                  ($urandom_range(5) == 0), rnd_target(),
                  ($urandom_range(5) == 0), rnd_target(),
                  ($urandom_range(15) == 0) ? $urandom() : pc_cur);
`ifdef SEQ_EXCEPTION_EN
            exc_i    = ($urandom_range(19) == 0);
            exc_pc_i = $urandom();
`endif
            model_eval();
            #1;
            check_outs("rand", e_pc, e_fv, e_fl, e_pend);
`ifdef SEQ_EXCEPTION_EN
            check("rand epc", epc_o, m_epc);
`endif
            @(posedge clk);
            model_step();
            pc_cur = e_pc;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the pipelined MIPS core. Each cycle it takes the current PC, the stall request and the redirect requests (EX branch, ID jump/jump-register). It computes the value written into the 32-bit program counter register, along with fetch-valid and flush indications for the IF/ID stage. It owns boot sequencing after reset and buffers a redirect that arrives while fetch is stalled, so no redirect is lost.

## Interface
Parameters:
- N_BITS, 32, address width
- RESET_PC, 32'h0040_0000, boot fetch address
- BOOT_CYCLES, 2, cycles PC is held at RESET_PC after reset release (0..15)
- EXC_VECTOR, 32'h8000_0180, exception entry address (used only with SEQ_EXCEPTION_EN)

Ports:
- clk  input  1  core clock; all state updates on posedge clk
- reset  input  1  synchronous, active-low reset (sampled on posedge clk)
- pc_value_i  input  N_BITS  current PC register value
- stall_i  input  1  hazard unit freezes fetch
- branch_taken_i  input  1  EX-stage branch resolved taken
- branch_target_i  input  N_BITS  branch destination
- jump_i  input  1  ID-stage j/jal
- jump_target_i  input  N_BITS  jump destination
- jr_i  input  1  ID-stage jr/jalr
- jr_target_i  input  N_BITS  register destination
- exc_i  input  1  exception request (SEQ_EXCEPTION_EN only)
- exc_pc_i  input  N_BITS  faulting instruction PC (SEQ_EXCEPTION_EN only)
- new_pc_o  output  N_BITS  next PC, combinational, to PC register input
- fetch_valid_o  output  1  instruction fetched this cycle is valid
- flush_o  output  1  squash IF/ID contents this cycle
- redirect_pending_o  output  1  registered; a redirect is buffered
- epc_o  output  N_BITS  registered exception PC (SEQ_EXCEPTION_EN only)

## Operation
- States: BOOT, RUN, PEND. Registers: state, 4-bit boot counter, pend_target_q, epc_q.
- Redirect priority, highest first: exception > branch_taken_i (older, EX) > jr_i > jump_i.
- All redirect targets have bits [1:0] forced to 2'b00 before use.
- PC+4 is computed modulo 2^N_BITS; 32'hFFFF_FFFC wraps to 0.
- BOOT:
  - new_pc_o=RESET_PC, fetch_valid_o=0, flush_o=0, all redirect inputs ignored.
  - The counter loads BOOT_CYCLES and decrements each cycle; the FSM moves to RUN when it reaches 0.
  - With BOOT_CYCLES=0, the FSM enters RUN on the first cycle after reset releases.
- RUN, no redirect: new_pc_o = stall_i ? pc_value_i : pc_value_i+4. fetch_valid_o = !stall_i.
- RUN, redirect and !stall_i: new_pc_o = winning target, flush_o=1, fetch_valid_o=0. The FSM stays in RUN.
- RUN, redirect and stall_i:
  - The winning target is latched into pend_target_q and the FSM moves to PEND.
  - new_pc_o=pc_value_i, flush_o=0.
- PEND:
  - new_pc_o=pc_value_i while stall_i=1; redirect_pending_o=1.
  - New branch, jr or jump requests are ignored, because they are wrong-path.
  - On the first cycle with stall_i=0: new_pc_o=pend_target_q, flush_o=1, then back to RUN.
- Reset low in any state, including mid-PEND:
  - Same cycle: new_pc_o=RESET_PC, fetch_valid_o=0, flush_o=0.
  - At the clock edge: state becomes BOOT, the counter reloads, and pend_target_q, redirect_pending_o and epc_q are cleared.

## Timing
- new_pc_o, flush_o and fetch_valid_o are combinational from inputs and state. A redirect therefore takes effect at the next PC edge (zero added latency).
- A buffered redirect is applied in the same cycle stall_i falls.
- redirect_pending_o rises the cycle after the capture and falls the cycle after release.
- Reset values of outputs:
  - new_pc_o = RESET_PC
  - fetch_valid_o = 0
  - flush_o = 0
  - redirect_pending_o = 0
  - epc_o = 0
- First valid fetch from RESET_PC occurs BOOT_CYCLES cycles after reset is sampled high.

## Configuration
- SEQ_EXCEPTION_EN defined:
  - exc_i, exc_pc_i and epc_o exist.
  - exc_i in RUN or PEND sets new_pc_o=EXC_VECTOR and flush_o=1, even while stall_i=1.
  - exc_i loads epc_q<=exc_pc_i, clears any pending redirect and returns the FSM to RUN.
  - A redirect target with bits [1:0]≠0 raises an internal exception with epc_q set to that target, instead of being masked.
  - exc_i is ignored in BOOT.
- SEQ_EXCEPTION_EN undefined: the exception ports and epc register are absent, and misaligned targets are silently masked.

## Test plan
- Reset low 3 cycles, release with BOOT_CYCLES=2 -> new_pc_o=0x0040_0000 for 2 cycles with fetch_valid_o=0, then 0x0040_0004, 0x0040_0008.
- RUN at PC 0x0040_0010, assert branch_taken_i (target 0x0040_0100) and jump_i (target 0x0040_0200) together -> new_pc_o=0x0040_0100, flush_o=1 for one cycle.
- stall_i=1 for 4 cycles with branch to 0x0040_0080 on cycle 1 and jump to 0x0040_0300 on cycle 2:
  - new_pc_o holds the current PC throughout and redirect_pending_o=1.
  - On release, new_pc_o=0x0040_0080 and flush_o=1.
- Reset asserted while in PEND -> pending cleared, new_pc_o=0x0040_0000, boot sequence repeats, buffered target never issued.
- pc_value_i=0xFFFF_FFFC, no redirect, no stall -> new_pc_o=0x0000_0000.
- SEQ_EXCEPTION_EN, stall_i=1 and exc_i with exc_pc_i=0x0040_0040 -> new_pc_o=0x8000_0180, flush_o=1, epc_o=0x0040_0040 next cycle. A jr target of 0x0040_0042 -> vector taken, epc_o=0x0040_0042.
